pipe_skid_buffer: RTL and testbench



---
 rtl/rv32i_types.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_skid_buffer.sv | 101 ++++++++++
 tb/tb_pipe_skid_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Types and constants shared by the pipeline stages.
// The bubble instruction is ADDI x0,x0,0; skid states are encoded as the held-beat count.
package rv32i_types;

  localparam logic [31:0] NOP_INST = 32'h13;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events: clears on rst, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Pipeline-stage register with a two-entry skid buffer, flush-to-bubble and a
// saturating back-pressure counter. Empty slots always hold NOP_VALUE.
module pipe_skid_buffer
  import rv32i_types::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_INST),
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: a beat moves on a side exactly when valid and ready are both high
  // at a rising edge; valid never waits on ready, and up_ready comes only from state.

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             up_fire, dn_fire;

  assign dn_valid  = (state_q != SKID_EMPTY);
  assign up_ready  = (state_q != SKID_TWO);
  assign dn_data   = main_q;
  assign occupancy = state_q;
  assign up_fire   = up_valid & up_ready;
  assign dn_fire   = dn_valid & dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (up_fire) begin
            state_d = SKID_ONE;
            main_d  = up_data;
          end
        end
        SKID_ONE: begin
          if (up_fire && dn_fire) begin
            main_d = up_data;
          end else if (up_fire) begin
            state_d = SKID_TWO;
            skid_d  = up_data;
          end else if (dn_fire) begin
            state_d = SKID_EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        SKID_TWO: begin
          // up_ready is low here, so only the drain side can move.
          if (dn_fire) begin
            state_d = SKID_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dn_valid & ~dn_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: a queue model checked every cycle on the default
// instance, plus directed literal checks on both it and a narrow, 3-bit-counter instance.
module tb_pipe_skid_buffer;

  localparam logic [31:0] NOP32 = 32'h13;
  localparam logic [7:0]  NOP8  = 8'hFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, up_valid = 1'b0, dn_ready = 1'b0;
  logic [31:0] up_data = '0;
  logic        up_ready, dn_valid;
  logic [31:0] dn_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic       s_rst = 1'b1, s_flush = 1'b0, s_up_valid = 1'b0, s_dn_ready = 1'b0;
  logic [7:0] s_up_data = '0;
  logic       s_up_ready, s_dn_valid;
  logic [7:0] s_dn_data;
  logic [1:0] s_occupancy;
  logic [2:0] s_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_buffer u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_buffer #(.WIDTH(8), .NOP_VALUE(8'hFF), .CNT_W(3)) u_small (
    .clk(clk), .rst(s_rst), .flush(s_flush),
    .up_valid(s_up_valid), .up_data(s_up_data), .up_ready(s_up_ready),
    .dn_valid(s_dn_valid), .dn_data(s_dn_data), .dn_ready(s_dn_ready),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the held beats as a FIFO queue, plus an event count.
  logic [31:0] mq[$];
  int unsigned mcnt = 0;

  always @(posedge clk) begin
    bit uf, df;
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      df = (mq.size() > 0) && dn_ready;
      uf = up_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !dn_ready && (mcnt < 65535)) mcnt++;
      if (df) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (uf) mq.push_back(up_data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_dn_valid", 64'(dn_valid), 64'(mq.size() > 0));
      chk("m_dn_data", 64'(dn_data), 64'((mq.size() > 0) ? mq[0] : NOP32));
      chk("m_up_ready", 64'(up_ready), 64'(mq.size() < 2));
      chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
      chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
    end
  end

  // Inputs change just after a falling edge and are held through the next rising edge;
  // the task returns at the following falling edge, when outputs are settled.
  task automatic drive(input bit r, input bit f, input bit uv, input logic [31:0] d, input bit dr);
    rst = r; flush = f; up_valid = uv; up_data = d; dn_ready = dr;
    @(negedge clk);
  endtask

  task automatic drive8(input bit r, input bit uv, input logic [7:0] d, input bit dr);
    s_rst = r; s_flush = 1'b0; s_up_valid = uv; s_up_data = d; s_dn_ready = dr;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dn_valid"}, 64'(dn_valid), 64'(0));
    chk({tag, "_dn_data"}, 64'(dn_data), 64'(NOP32));
    chk({tag, "_up_ready"}, 64'(up_ready), 64'(1));
    chk({tag, "_occupancy"}, 64'(occupancy), 64'(0));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
  endtask

  initial begin
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    check_en = 1'b1;
    chk_reset("reset");

    // Streaming at full rate.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 1, 32'(k), 1);
      chk("stream_data", 64'(dn_data), 64'(k));
      chk("stream_occ", 64'(occupancy), 64'(1));
    end
    drive(0, 0, 0, 0, 1);
    chk("stream_drain_valid", 64'(dn_valid), 64'(0));
    chk("stream_stall", 64'(stall_cnt), 64'(0));

    // Skid fill and drain.
    drive(0, 0, 1, 32'hA, 1);
    drive(0, 0, 1, 32'hB, 0);
    chk("skid_occ", 64'(occupancy), 64'(2));
    chk("skid_up_ready", 64'(up_ready), 64'(0));
    chk("skid_stall1", 64'(stall_cnt), 64'(1));
    drive(0, 0, 0, 0, 0);
    chk("skid_stall2", 64'(stall_cnt), 64'(2));
    chk("skid_head", 64'(dn_data), 64'(32'hA));
    drive(0, 0, 0, 0, 1);
    chk("skid_second", 64'(dn_data), 64'(32'hB));
    chk("skid_up_ready_back", 64'(up_ready), 64'(1));
    drive(0, 0, 0, 0, 1);
    chk("skid_empty_valid", 64'(dn_valid), 64'(0));
    chk("skid_empty_data", 64'(dn_data), 64'(NOP32));

    // Reset held while in TWO.
    drive(0, 0, 1, 32'h11, 0);
    drive(0, 0, 1, 32'h22, 0);
    chk("pre_reset_occ", 64'(occupancy), 64'(2));
    chk("pre_reset_stall", 64'(stall_cnt), 64'(3));
    drive(1, 0, 1, 32'h33, 0);
    chk_reset("midreset");

    // Flush in TWO with a beat offered on the same cycle.
    drive(0, 0, 1, 32'h44, 0);
    drive(0, 0, 1, 32'h55, 0);
    drive(0, 1, 1, 32'hC, 0);
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_data", 64'(dn_data), 64'(NOP32));
    chk("flush_up_ready", 64'(up_ready), 64'(1));
    chk("flush_stall_kept", 64'(stall_cnt), 64'(2));
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk("flush_no_c", 64'(dn_valid), 64'(0));

    // Flush in ONE while both sides fire: the up beat is dropped.
    drive(0, 0, 1, 32'h66, 1);
    drive(0, 1, 1, 32'h77, 1);
    chk("flush_one_valid", 64'(dn_valid), 64'(0));

    // Flush together with reset behaves as reset.
    drive(0, 0, 1, 32'h88, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 1, 32'h99, 0);
    chk_reset("flush_rst");

    // Mixed traffic, model-checked every cycle.
    for (int i = 0; i < 60; i++) begin
      drive(0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            $urandom, ($urandom_range(0, 2) != 0));
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Narrow instance: custom bubble and 3-bit saturation.
    drive8(1, 0, 8'h00, 0);
    chk("w8_reset_data", 64'(s_dn_data), 64'(NOP8));
    chk("w8_reset_valid", 64'(s_dn_valid), 64'(0));
    chk("w8_reset_stall", 64'(s_stall_cnt), 64'(0));
    drive8(0, 1, 8'h00, 1);
    chk("w8_zero_data", 64'(s_dn_data), 64'(0));
    chk("w8_zero_valid", 64'(s_dn_valid), 64'(1));
    for (int k = 1; k <= 10; k++) begin
      drive8(0, 0, 8'h00, 0);
      chk("w8_sat", 64'(s_stall_cnt), 64'((k < 7) ? k : 7));
    end
    drive8(0, 0, 8'h00, 1);
    chk("w8_drained_data", 64'(s_dn_data), 64'(NOP8));
    chk("w8_sat_hold", 64'(s_stall_cnt), 64'(7));

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
